// File: rtl/output_decoder.sv
// Four-digit keypad entry buffer with a multiplexed, active-low 7-segment scan driver.
// Define OUTPUT_DECODER_BLINK_EN to blink the display at the pgt_1hz rate while full.
module output_decoder #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] digit,
  input  logic       pgt_1hz,
  input  logic       clear_entry,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [2:0] count,
  output logic       full
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic             r_load_d;
  logic [3:0][3:0]  r_buf;
  logic [2:0]       r_count;
  logic [15:0]      r_scan;
  logic [1:0]       r_pos;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;

  logic             w_load_edge;
  logic             w_full;
  logic [3:0]       w_cur;
  logic             w_blank_pos;
  logic             w_blink_off;
  logic [6:0]       w_seg_dec;

  assign w_load_edge = load & ~r_load_d;
  assign w_full      = (r_count == 3'd4);
  assign w_cur       = r_buf[r_pos];
  assign w_blank_pos = ({1'b0, r_pos} >= r_count);

  // Entry buffer: position 0 holds the newest digit; clear beats a same-cycle load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_d <= 1'b0;
      r_buf    <= '0;
      r_count  <= '0;
    end else begin
      r_load_d <= load;
      if (clear_entry) begin
        r_buf   <= '0;
        r_count <= '0;
      end else if (w_load_edge && !w_full) begin
        r_buf   <= {r_buf[2:0], digit};
        r_count <= r_count + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan <= '0;
      r_pos  <= '0;
    end else if (r_scan == SCAN_LAST) begin
      r_scan <= '0;
      r_pos  <= r_pos + 2'd1;
    end else begin
      r_scan <= r_scan + 16'd1;
    end
  end

`ifdef OUTPUT_DECODER_BLINK_EN
  logic r_pgt_d;
  logic r_blink;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pgt_d <= 1'b0;
      r_blink <= 1'b1;
    end else begin
      r_pgt_d <= pgt_1hz;
      if (!w_full)
        r_blink <= 1'b1;
      else if (pgt_1hz && !r_pgt_d)
        r_blink <= ~r_blink;
    end
  end

  assign w_blink_off = w_full & ~r_blink;
`else
  logic w_unused_pgt;
  assign w_unused_pgt = pgt_1hz;
  assign w_blink_off  = 1'b0;
`endif

  always_comb begin
    w_seg_dec = 7'b1111111;
    case (w_cur)
      4'd0: w_seg_dec = 7'b0000001;
      4'd1: w_seg_dec = 7'b1001111;
      4'd2: w_seg_dec = 7'b0010010;
      4'd3: w_seg_dec = 7'b0000110;
      4'd4: w_seg_dec = 7'b1001100;
      4'd5: w_seg_dec = 7'b0100100;
      4'd6: w_seg_dec = 7'b0100000;
      4'd7: w_seg_dec = 7'b0001111;
      4'd8: w_seg_dec = 7'b0000000;
      4'd9: w_seg_dec = 7'b0000100;
      default: w_seg_dec = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= '1;
      r_an  <= 4'b1110;
    end else begin
      r_seg <= (w_blank_pos || w_blink_off) ? 7'b1111111 : w_seg_dec;
      r_an  <= ~(4'b0001 << r_pos);
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign count = r_count;
  assign full  = w_full;

endmodule
